// File: rtl/calc_pkg.sv
// calc_pkg: constants, FSM encoding and helpers shared by the calculator units.
package calc_pkg;
  localparam int OP_W = 32;
  localparam int RES_W = 2 * OP_W;
  localparam int MUL_LAT = OP_W + 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  function automatic logic [RES_W-1:0] twos_neg(input logic [RES_W-1:0] x, input logic neg);
    return neg ? -x : x;
  endfunction
endpackage

// File: rtl/calc_mul_seq_if.sv
// calc_mul_seq_if: start/done handshake and operand/product bus of the multiplier.
interface calc_mul_seq_if #(parameter int OP_W = 32);
  logic start;
  logic is_signed;
  logic [OP_W-1:0] a;
  logic [OP_W-1:0] b;
  logic busy;
  logic done;
  logic [2*OP_W-1:0] product;
  modport master(output start, is_signed, a, b, input busy, done, product);
  modport slave(input start, is_signed, a, b, output busy, done, product);
endinterface

// File: rtl/calc_mul_seq.sv
// calc_mul_seq: iterative shift-add multiplier, signed or unsigned, OP_W+1 cycle latency.
module calc_mul_seq #(
  parameter int OP_W = 32
) (
  input logic clk,
  input logic rst,
  calc_mul_seq_if.slave bus
);
  import calc_pkg::*;
  localparam int RW = 2 * OP_W;
  localparam int CW = $clog2(OP_W);
  state_t r_state, w_next;
  logic [CW-1:0] r_cnt;
  logic [RW-1:0] r_mcand, r_acc, r_prod, w_acc;
  logic [OP_W-1:0] r_mplier, w_abs_a, w_abs_b;
  logic r_neg, r_busy, r_done, w_load, w_last, w_sgn_a, w_sgn_b;
  // signed operands are iterated as magnitudes; the sign is reapplied at the end
  assign w_sgn_a = bus.is_signed & bus.a[OP_W-1];
  assign w_sgn_b = bus.is_signed & bus.b[OP_W-1];
  assign w_abs_a = OP_W'(twos_neg(RES_W'(bus.a), w_sgn_a));
  assign w_abs_b = OP_W'(twos_neg(RES_W'(bus.b), w_sgn_b));
  assign w_acc = r_acc + (r_mplier[0] ? r_mcand : '0);
  always_comb begin
    w_load = bus.start && (r_state != RUN);
    w_last = (r_state == RUN) && (r_cnt == CW'(OP_W - 1));
    w_next = w_load ? RUN : w_last ? DONE : (r_state == DONE) ? IDLE : r_state;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_busy <= 1'b0;
      r_done <= 1'b0;
      r_cnt <= '0;
      r_acc <= '0;
      r_mcand <= '0;
      r_mplier <= '0;
      r_neg <= 1'b0;
      r_prod <= '0;
    end else begin
      r_state <= w_next;
      r_busy <= (w_next == RUN);
      r_done <= (w_next == DONE);
      if (w_load) begin
        r_mcand <= RW'(w_abs_a);
        r_mplier <= w_abs_b;
        r_neg <= w_sgn_a ^ w_sgn_b;
        r_acc <= '0;
        r_cnt <= '0;
      end else if (r_state == RUN) begin
        r_acc <= w_acc;
        r_mcand <= r_mcand << 1;
        r_mplier <= r_mplier >> 1;
        r_cnt <= r_cnt + 1'b1;
      end
      if (w_last) r_prod <= RW'(twos_neg(RES_W'(w_acc), r_neg));
    end
  end
  assign bus.busy = r_busy;
  assign bus.done = r_done;
  assign bus.product = r_prod;
endmodule

// File: tb/tb_calc_mul_seq.sv
// tb_calc_mul_seq: directed and random multiplies checked against a product scoreboard.
module tb_calc_mul_seq;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;
  logic [63:0] exp_q[$];
  logic [63:0] last_prod = '0;
  calc_mul_seq_if #(.OP_W(32)) bus();
  calc_mul_seq #(.OP_W(32)) dut(.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  function automatic logic [63:0] model(input logic [31:0] x, input logic [31:0] y, input logic s);
    return s ? $signed({{32{x[31]}}, x}) * $signed({{32{y[31]}}, y}) : {32'b0, x} * {32'b0, y};
  endfunction
  task automatic run_op(input string tag, input logic [31:0] x, input logic [31:0] y, input logic s,
                        input logic [63:0] exp, input bit now, input bit mid);
    int n = 0;
    bit got = 0;
    if (!now) @(negedge clk);
    bus.start = 1'b1;
    bus.a = x;
    bus.b = y;
    bus.is_signed = s;
    exp_q.push_back(exp);
    while (!got && n < 40) begin
      @(negedge clk);
      n++;
      if (n == 1) begin
        bus.start = 1'b0;
        bus.a = ~x;
        bus.is_signed = ~s;
        check({tag, "_busy_rise"}, 64'(bus.busy), 64'd1);
        check({tag, "_prod_hold"}, bus.product, last_prod);
      end
      if (mid && n == 10) begin
        bus.start = 1'b1;
        bus.a = 32'h1234_5678;
        bus.b = 32'h0000_0003;
      end
      if (mid && n == 11) bus.start = 1'b0;
      if (bus.done) got = 1;
    end
    check({tag, "_done_seen"}, 64'(got), 64'd1);
    check({tag, "_latency"}, 64'(n), 64'd33);
    check({tag, "_busy_low"}, 64'(bus.busy), 64'd0);
    check({tag, "_queue"}, 64'(exp_q.size()), 64'd1);
    if (exp_q.size() != 0) begin
      last_prod = exp_q.pop_front();
      check({tag, "_product"}, bus.product, last_prod);
    end
  endtask
  task automatic count_dones(input string tag, input int cycles);
    int d = 0;
    repeat (cycles) begin
      @(negedge clk);
      if (bus.done) d++;
    end
    check(tag, 64'(d), 64'd0);
  endtask
  initial begin
    logic [31:0] ra, rb;
    logic rs;
    bus.start = 1'b0;
    bus.is_signed = 1'b0;
    bus.a = '0;
    bus.b = '0;
    repeat (2) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_product", bus.product, 64'd0);
    rst = 1'b0;
    run_op("u7x6", 32'd7, 32'd6, 1'b0, 64'h0000_0000_0000_002A, 0, 0);
    run_op("s_m3x5", 32'hFFFF_FFFD, 32'd5, 1'b1, 64'hFFFF_FFFF_FFFF_FFF1, 0, 0);
    run_op("u_m3x5", 32'hFFFF_FFFD, 32'd5, 1'b0, 64'h0000_0004_FFFF_FFF1, 0, 0);
    run_op("u_max2", 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 64'hFFFF_FFFE_0000_0001, 0, 0);
    run_op("s_min2", 32'h8000_0000, 32'h8000_0000, 1'b1, 64'h4000_0000_0000_0000, 0, 0);
    run_op("s_minx1", 32'h8000_0000, 32'd1, 1'b1, 64'hFFFF_FFFF_8000_0000, 0, 0);
    run_op("mid_start", 32'd100, 32'd200, 1'b0, 64'd20000, 0, 1);
    count_dones("mid_extra_done", 40);
    run_op("b2b_first", 32'd5, 32'd5, 1'b0, 64'd25, 0, 0);
    run_op("b2b_second", 32'd2, 32'd3, 1'b0, 64'd6, 1, 0);
    @(negedge clk);
    check("done_pulse_width", 64'(bus.done), 64'd0);
    bus.start = 1'b1;
    bus.a = 32'd9;
    bus.b = 32'd9;
    repeat (11) @(negedge clk);
    bus.start = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst_busy", 64'(bus.busy), 64'd0);
    check("midrst_done", 64'(bus.done), 64'd0);
    check("midrst_product", bus.product, 64'd0);
    last_prod = '0;
    count_dones("midrst_no_done", 40);
    rst = 1'b1;
    bus.start = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    bus.start = 1'b0;
    check("rst_start_busy", 64'(bus.busy), 64'd0);
    count_dones("rst_start_no_done", 40);
    run_op("fresh", 32'd11, 32'd13, 1'b1, 64'd143, 0, 0);
    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom;
      rs = 1'($urandom_range(1));
      run_op("rand", ra, rb, rs, model(ra, rb, rs), 0, 0);
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
